// File: rtl/jtframe_snd_interp.sv
// rtl/jtframe_snd_interp.sv - linear interpolator between core-domain audio samples and the DAC word
// A toggle announces each new sample; the output ramps to it over 2^SHIFT cen steps.
module jtframe_snd_interp #(
   parameter logic SIGNED_SND = 1'b0,
   parameter int   SHIFT      = 5
) (
   input  logic        rst,
   input  logic        clk_dac,
   input  logic        cen,
   input  logic [15:0] snd_in,
   input  logic        snd_tgl,
   output logic [19:0] pcm_out,
   output logic        pcm_stb,
   output logic        overrun
);

   localparam int AW = 16 + SHIFT;
   localparam int CW = SHIFT + 1;
   localparam logic [CW-1:0] LAST = CW'((1 << SHIFT) - 1);

   typedef enum logic { IDLE, RAMP } state_t;

   state_t          state, nxt_state;
   logic [AW-1:0]   acc, nxt_acc;
   logic [16:0]     delta, nxt_delta;
   logic [15:0]     target, nxt_target;
   logic [CW-1:0]   cnt, nxt_cnt;
   logic            nxt_ovr;
   logic            step, step_q;
   logic            tgl_s1, tgl_s2, tgl_q;
   logic [2:0]      arm;
   logic            new_evt;
   logic [15:0]     snd_conv;
   logic [AW:0]     diff;

   // arm holds off edge detection until tgl_q has captured the post-reset level
   assign new_evt  = arm[2] & (tgl_s2 ^ tgl_q);
   assign snd_conv = {snd_in[15] ^ SIGNED_SND, snd_in[14:0]};
   assign diff     = {1'b0, snd_conv, {SHIFT{1'b0}}} - {1'b0, acc};

   always_ff @(posedge clk_dac or posedge rst) begin
      if (rst) begin
         tgl_s1 <= 1'b0;
         tgl_s2 <= 1'b0;
         tgl_q  <= 1'b0;
         arm    <= 3'd0;
      end else begin
         tgl_s1 <= snd_tgl;
         tgl_s2 <= tgl_s1;
         tgl_q  <= tgl_s2;
         arm    <= {arm[1:0], 1'b1};
      end
   end

   always_comb begin
      nxt_state  = state;
      nxt_acc    = acc;
      nxt_delta  = delta;
      nxt_target = target;
      nxt_cnt    = cnt;
      nxt_ovr    = overrun;
      step       = 1'b0;
      if (new_evt) begin
         nxt_target = snd_conv;
         nxt_delta  = diff[AW:SHIFT];
         nxt_cnt    = '0;
         nxt_state  = RAMP;
         if (state == RAMP) nxt_ovr = 1'b1;
      end else if (state == RAMP && cen) begin
         step    = 1'b1;
         nxt_cnt = cnt + 1'b1;
         // last step lands exactly on the target, discarding truncation residue
         if (cnt == LAST) begin
            nxt_acc   = {target, {SHIFT{1'b0}}};
            nxt_state = IDLE;
         end else begin
            nxt_acc = acc + AW'($signed(delta));
         end
      end
   end

   always_ff @(posedge clk_dac or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= {16'h8000, {SHIFT{1'b0}}};
         delta   <= '0;
         target  <= 16'h8000;
         cnt     <= '0;
         overrun <= 1'b0;
         step_q  <= 1'b0;
         pcm_out <= 20'h40000;
         pcm_stb <= 1'b0;
      end else begin
         state   <= nxt_state;
         acc     <= nxt_acc;
         delta   <= nxt_delta;
         target  <= nxt_target;
         cnt     <= nxt_cnt;
         overrun <= nxt_ovr;
         step_q  <= step;
         pcm_out <= {1'b0, acc[AW-1:SHIFT], 3'd0};
         pcm_stb <= step_q;
      end
   end

endmodule

// File: tb/tb_jtframe_snd_interp.sv
// tb/tb_jtframe_snd_interp.sv - scoreboard bench for jtframe_snd_interp with SHIFT=2, cen every 4th clock
// u0 uses offset-binary input, u1 two's complement.
module tb_jtframe_snd_interp;

   logic        clk_dac = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b0;
   logic [15:0] snd0 = 16'h0000, snd1 = 16'h0000;
   logic        tgl0 = 1'b0, tgl1 = 1'b0;
   logic [19:0] pcm_out0, pcm_out1;
   logic        pcm_stb0, pcm_stb1, overrun0, overrun1;

   int          n_assert = 0;
   int          n_fail = 0;
   int          n_stb0 = 0, n_stb1 = 0;
   int          ph = 0;
   time         t0, t_stb0;
   logic [15:0] q0[$], q1[$];

   jtframe_snd_interp #(.SIGNED_SND(1'b0), .SHIFT(2)) u0 (
      .rst(rst), .clk_dac(clk_dac), .cen(cen), .snd_in(snd0), .snd_tgl(tgl0),
      .pcm_out(pcm_out0), .pcm_stb(pcm_stb0), .overrun(overrun0));

   jtframe_snd_interp #(.SIGNED_SND(1'b1), .SHIFT(2)) u1 (
      .rst(rst), .clk_dac(clk_dac), .cen(cen), .snd_in(snd1), .snd_tgl(tgl1),
      .pcm_out(pcm_out1), .pcm_stb(pcm_stb1), .overrun(overrun1));

   initial forever #5 clk_dac = ~clk_dac;

   initial forever begin
      @(negedge clk_dac);
      ph  = (ph + 1) % 4;
      cen = (ph == 0);
   end

   initial begin : monitor
      logic [15:0] e;
      forever begin
         @(negedge clk_dac);
         if (pcm_stb0) begin
            n_stb0++;
            if (t_stb0 == 0) t_stb0 = $time;
            n_assert++;
            assert (q0.size() > 0) else begin
               n_fail++; $error("FAIL u0_unexpected_stb observed level %h expected no strobe", pcm_out0[18:3]);
            end
            if (q0.size() > 0) begin
               e = q0.pop_front();
               n_assert++;
               assert (pcm_out0 === {1'b0, e, 3'd0}) else begin
                  n_fail++; $error("FAIL u0_level observed %h expected %h", pcm_out0, {1'b0, e, 3'd0});
               end
            end
         end
         if (pcm_stb1) begin
            n_stb1++;
            n_assert++;
            assert (q1.size() > 0) else begin
               n_fail++; $error("FAIL u1_unexpected_stb observed level %h expected no strobe", pcm_out1[18:3]);
            end
            if (q1.size() > 0) begin
               e = q1.pop_front();
               n_assert++;
               assert (pcm_out1 === {1'b0, e, 3'd0}) else begin
                  n_fail++; $error("FAIL u1_level observed %h expected %h", pcm_out1, {1'b0, e, 3'd0});
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++; $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cen();
      do @(posedge clk_dac); while (cen !== 1'b1);
   endtask

   task automatic wait_cens(input int n);
      repeat (n) wait_cen();
   endtask

   task automatic drain(input string tag, input int budget);
      int i = 0;
      while ((q0.size() != 0 || q1.size() != 0) && i < budget) begin
         @(negedge clk_dac);
         i++;
      end
      n_assert++;
      assert (q0.size() == 0 && q1.size() == 0) else begin
         n_fail++; $error("FAIL %s observed pending %0d/%0d expected 0/0", tag, q0.size(), q1.size());
      end
   endtask

   initial begin : stim
      int n;
      t_stb0 = 0;
      // reset state and quiet idle
      repeat (3) @(negedge clk_dac);
      chk("rst_pcm0", 32'(pcm_out0), 32'h40000);
      chk("rst_stb0", 32'(pcm_stb0), 32'h0);
      chk("rst_ovr0", 32'(overrun0), 32'h0);
      chk("rst_pcm1", 32'(pcm_out1), 32'h40000);
      rst = 1'b0;
      wait_cens(100);
      chk("idle_stb_count", 32'(n_stb0 + n_stb1), 32'h0);

      // full ramp 0x8000 -> 0x9000
      wait_cen(); t0 = $time;
      @(negedge clk_dac);
      snd0 = 16'h9000; t_stb0 = 0;
      q0.push_back(16'h8400); q0.push_back(16'h8800); q0.push_back(16'h8C00); q0.push_back(16'h9000);
      tgl0 = ~tgl0;
      drain("ramp_9000", 200);
      chk("ramp_latency", 32'(t_stb0 - t0), 32'd55);
      chk("ramp_ovr", 32'(overrun0), 32'h0);
      n = n_stb0;
      wait_cens(20);
      chk("hold_stb", 32'(n_stb0 - n), 32'h0);
      chk("hold_pcm", 32'(pcm_out0), 32'h48000);

      // new_evt lands on a cen edge: first step on the following cen
      wait_cen(); t0 = $time;
      @(negedge clk_dac); @(negedge clk_dac);
      snd0 = 16'h8000; t_stb0 = 0;
      q0.push_back(16'h8C00); q0.push_back(16'h8800); q0.push_back(16'h8400); q0.push_back(16'h8000);
      tgl0 = ~tgl0;
      drain("coincide", 200);
      chk("coincide_latency", 32'(t_stb0 - t0), 32'd95);
      chk("coincide_ovr", 32'(overrun0), 32'h0);

      // second sample two steps into a ramp
      wait_cen();
      @(negedge clk_dac);
      snd0 = 16'h9000;
      q0.push_back(16'h8400); q0.push_back(16'h8800);
      tgl0 = ~tgl0;
      wait_cens(2);
      @(negedge clk_dac);
      snd0 = 16'h8000;
      q0.push_back(16'h8600); q0.push_back(16'h8400); q0.push_back(16'h8200); q0.push_back(16'h8000);
      tgl0 = ~tgl0;
      drain("overrun_ramp", 200);
      chk("overrun_set", 32'(overrun0), 32'h1);
      chk("overrun_pcm", 32'(pcm_out0), 32'h40000);
      wait_cens(10);
      chk("overrun_sticky", 32'(overrun0), 32'h1);

      // signed input: full-scale swings
      wait_cen(); @(negedge clk_dac);
      snd1 = 16'h8000;
      q1.push_back(16'h6000); q1.push_back(16'h4000); q1.push_back(16'h2000); q1.push_back(16'h0000);
      tgl1 = ~tgl1;
      drain("signed_min", 200);
      wait_cen(); @(negedge clk_dac);
      snd1 = 16'h7FFF;
      q1.push_back(16'h3FFF); q1.push_back(16'h7FFF); q1.push_back(16'hBFFF); q1.push_back(16'hFFFF);
      tgl1 = ~tgl1;
      drain("signed_up", 200);
      chk("signed_top", 32'(pcm_out1), 32'h7FFF8);
      wait_cen(); @(negedge clk_dac);
      snd1 = 16'h8000;
      q1.push_back(16'hBFFF); q1.push_back(16'h7FFF); q1.push_back(16'h3FFF); q1.push_back(16'h0000);
      tgl1 = ~tgl1;
      drain("signed_down", 200);
      chk("signed_ovr", 32'(overrun1), 32'h0);

      // reset mid-ramp, with both toggles held high across it
      wait_cen(); @(negedge clk_dac);
      snd0 = 16'h9000;
      q0.push_back(16'h8400);
      tgl0 = ~tgl0;
      wait_cen();
      repeat (3) @(negedge clk_dac);
      chk("midrst_before", 32'(pcm_out0), 32'h42000);
      rst = 1'b1;
      #1;
      chk("midrst_pcm", 32'(pcm_out0), 32'h40000);
      chk("midrst_ovr", 32'(overrun0), 32'h0);
      chk("midrst_pcm1", 32'(pcm_out1), 32'h40000);
      repeat (3) @(negedge clk_dac);
      rst = 1'b0;
      n = n_stb0 + n_stb1;
      wait_cens(30);
      chk("midrst_no_resume", 32'(n_stb0 + n_stb1 - n), 32'h0);
      chk("midrst_hold", 32'(pcm_out0), 32'h40000);
      chk("midrst_q", 32'(q0.size() + q1.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/jtframe_snd_interp.md
JTFRAME_SND_INTERP -- requirements
Module: jtframe_snd_interp

Interface
REQ-001 The block SHALL have parameter SIGNED_SND, default 1'b0, meaning snd_in is two's complement when 1 and offset binary when 0.
REQ-002 The block SHALL have parameter SHIFT, default 5, meaning log2 of the number of cen steps per interpolation ramp; legal range is 1..8.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port clk_dac, input, 1 bit: the DAC clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port cen, input, 1 bit: DAC clock enable; the ramp advances only on cycles where cen is high.
REQ-006 The block SHALL have port snd_in, input, 16 bits: audio sample from the core clock domain, held stable from one snd_tgl transition to the next.
REQ-007 The block SHALL have port snd_tgl, input, 1 bit: a source-domain toggle; each transition announces a new snd_in.
REQ-008 The block SHALL have port pcm_out, output, 20 bits: DAC word {1'b0, offset-binary 16-bit level, 3'd0}, for direct connection to the 1-bit DAC pcm_in.
REQ-009 The block SHALL have port pcm_stb, output, 1 bit: one-cycle pulse whenever pcm_out changes.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a new sample arrives before the current ramp completes.

Function
REQ-011 snd_tgl SHALL pass through a 2-FF synchronizer followed by an edge-detect register; the resulting new_evt pulse is 1 clk_dac wide, 3 clk_dac cycles after the toggle.
REQ-012 On new_evt, snd_in SHALL be sampled directly (no synchronizer) and converted to target = {snd_in[15]^SIGNED_SND, snd_in[14:0]}.
REQ-013 The accumulator acc SHALL be 16+SHIFT bits: integer level in acc[15+SHIFT:SHIFT], fraction below it.
REQ-014 On new_evt: delta (17-bit signed, sign-extended into the acc width) = {target,SHIFT'b0} - acc; step counter = 0; state = RAMP.
REQ-015 The block SHALL have the states IDLE (acc held) and RAMP (acc advancing).
REQ-016 In RAMP, on each cen cycle: acc += delta, counter += 1, pcm_out updated, pcm_stb pulsed.
REQ-017 When counter reaches 2^SHIFT, acc SHALL be forced to exactly {target,SHIFT'b0}, with no rounding residue, and state SHALL return to IDLE.
REQ-018 pcm_out SHALL be registered as {1'b0, acc[15+SHIFT:SHIFT], 3'd0}; latency is 1 clk_dac cycle after the cen that updated acc.
REQ-019 If new_evt and cen coincide, new_evt SHALL win: acc is not advanced, the ramp restarts from the current acc, and no pcm_stb is generated that cycle.
REQ-020 If new_evt occurs in RAMP, overrun SHALL be set and the new ramp SHALL start from the current acc, not from the old target; no output jump occurs.
REQ-021 In IDLE, cen SHALL cause no change to any register and no pcm_stb.
REQ-022 The full-scale swing from 0x0000 to 0xFFFF (and the reverse) SHALL ramp without accumulator wrap-around.

Reset
REQ-023 While rst is high: acc = {16'h8000, SHIFT'b0}, pcm_out = 20'h40000, pcm_stb = 0, overrun = 0, state = IDLE, counter = 0, synchronizer and edge registers = 0.
REQ-024 After rst deasserts, the first sample SHALL ramp from midscale 0x8000.
REQ-025 A reset asserted mid-ramp SHALL abort the ramp immediately; the held snd_tgl level is then treated as the baseline and produces no new_evt.
REQ-026 overrun SHALL be cleared only by rst.

Verification (SHIFT=2, cen every 4th clk_dac)
REQ-027 Reset -> pcm_out = 20'h40000, pcm_stb = 0, overrun = 0, with no pcm_stb over 100 cen cycles.
REQ-028 SIGNED_SND=0, snd_in = 0x9000, toggle -> level sequence 0x8400, 0x8800, 0x8C00, 0x9000 on 4 consecutive cen cycles, 4 pcm_stb pulses, then constant.
REQ-029 SIGNED_SND=1, snd_in = 0x8000 (-32768) from reset -> levels 0x6000, 0x4000, 0x2000, 0x0000; a subsequent 0x7FFF (0xFFFF offset) -> final level exactly 0xFFFF with no wrap.
REQ-030 Second toggle 2 cen cycles into the 0x9000 ramp with snd_in = 0x8000 -> overrun = 1, ramp from 0x8800 down: 0x8600, 0x8400, 0x8200, 0x8000.
REQ-031 new_evt coincident with cen -> no acc step or pcm_stb that cycle; the ramp begins on the next cen.
REQ-032 rst pulse at step 2 of a ramp -> pcm_out = 20'h40000 immediately; no ramp resumes without a fresh toggle.
